// File: rtl/register_file_if.sv
// Register file bus bundle: two combinational read ports, one write port and
// the streaming debug-dump port with its status flags.
//   master : the client side (drives addresses, write data, dump_start, dbg_ready)
//   slave  : the register file side (drives read data, debug stream, status)
interface register_file_if #(
  parameter int n = 32
);
  logic [4:0]   rs1_addr;
  logic [4:0]   rs2_addr;
  logic [n-1:0] rs1_data;
  logic [n-1:0] rs2_data;
  logic         reg_write;
  logic [4:0]   rd_addr;
  logic [n-1:0] rd_data;
  logic         dump_start;
  logic         dbg_valid;
  logic         dbg_ready;
  logic [4:0]   dbg_addr;
  logic [n-1:0] dbg_data;
  logic         dump_busy;
  logic         dump_done;

  modport master (
    output rs1_addr, rs2_addr, reg_write, rd_addr, rd_data, dump_start, dbg_ready,
    input  rs1_data, rs2_data, dbg_valid, dbg_addr, dbg_data, dump_busy, dump_done
  );

  modport slave (
    input  rs1_addr, rs2_addr, reg_write, rd_addr, rd_data, dump_start, dbg_ready,
    output rs1_data, rs2_data, dbg_valid, dbg_addr, dbg_data, dump_busy, dump_done
  );
endinterface

// File: rtl/register_file.sv
// 32-entry register file with x0 hardwired to zero, two combinational read
// ports with write-before-read bypass, and a debug port that streams all 32
// registers out over a valid/ready handshake on a one-cycle dump_start request.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   bus      : register_file_if.slave (read/write ports, debug stream, status)
module register_file #(
  parameter int n     = 32,
  parameter int DEPTH = 32
) (
  input logic            clk,
  input logic            rst,
  register_file_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t       state;
  logic [n-1:0] regs [DEPTH];
  logic         valid_q;
  logic         busy_q;
  logic         done_q;
  logic [4:0]   dbg_addr_q;
  logic         wr_en;

  // Writes to x0 are dropped here so neither storage nor bypass ever sees them.
  assign wr_en = bus.reg_write && (bus.rd_addr != 5'd0);

  // One read path shared by both read ports and the debug port: reset forces
  // zero, an in-flight write to the same address is forwarded, x0 reads zero.
  function automatic logic [n-1:0] read_port(
    input logic [4:0]   addr,
    input logic [n-1:0] stored,
    input logic         rst_i,
    input logic         we,
    input logic [4:0]   wa,
    input logic [n-1:0] wd
  );
    if (rst_i)
      return '0;
    if (we && (wa == addr))
      return wd;
    if (addr == 5'd0)
      return '0;
    return stored;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= '0;
    end else if (wr_en) begin
      regs[bus.rd_addr] <= bus.rd_data;
    end
  end

  // Dump sequencer. The address never wraps: the accepted word at x31 moves
  // to DONE, which holds dump_done for a single cycle before returning idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dbg_addr_q <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.dump_start) begin
            state      <= SEND;
            valid_q    <= 1'b1;
            busy_q     <= 1'b1;
            dbg_addr_q <= 5'd0;
          end
        end
        SEND: begin
          if (bus.dbg_ready) begin
            if (dbg_addr_q == 5'd31) begin
              state   <= DONE;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              dbg_addr_q <= dbg_addr_q + 5'd1;
            end
          end
        end
        DONE: begin
          state      <= IDLE;
          done_q     <= 1'b0;
          busy_q     <= 1'b0;
          dbg_addr_q <= 5'd0;
        end
        default: begin
          state   <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rs1_data  = read_port(bus.rs1_addr, regs[bus.rs1_addr], rst, wr_en, bus.rd_addr, bus.rd_data);
  assign bus.rs2_data  = read_port(bus.rs2_addr, regs[bus.rs2_addr], rst, wr_en, bus.rd_addr, bus.rd_data);
  assign bus.dbg_data  = read_port(dbg_addr_q, regs[dbg_addr_q], rst, wr_en, bus.rd_addr, bus.rd_data);
  assign bus.dbg_addr  = dbg_addr_q;

  // Status flags are registered but forced low while reset is asserted.
  assign bus.dbg_valid = valid_q & ~rst;
  assign bus.dump_busy = busy_q & ~rst;
  assign bus.dump_done = done_q & ~rst;

endmodule

// File: tb/tb_register_file.sv
module tb_register_file;
  logic clk = 1'b0;
  logic rst;

  register_file_if #(.n(32)) bus ();

  register_file #(.n(32), .DEPTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] mdl [32];
  logic [36:0] exp_q [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus.reg_write = 1'b1;
    bus.rd_addr   = a;
    bus.rd_data   = d;
    if (a != 5'd0) mdl[a] = d;
    tick();
    bus.reg_write = 1'b0;
  endtask

  // Queue the expected stream from the model, then pulse dump_start.
  task automatic start_dump();
    for (int i = 0; i < 32; i++)
      exp_q.push_back({5'(i), mdl[i]});
    bus.dump_start = 1'b1;
    tick();
    bus.dump_start = 1'b0;
  endtask

  // Runs until dump_done or budget. 'toggle' alternates dbg_ready; 'extras'
  // adds a stalled write, a bypassed write on a transfer and a stray dump_start.
  task automatic run_dump(input bit toggle, input bit extras, input int max, output int cycles);
    bit did_stall_wr = 0;
    bit did_byp_wr   = 0;
    cycles = 1;
    while (cycles < max) begin
      @(negedge clk);
      if (bus.dump_done === 1'b1) break;
      tick();
      cycles++;
      bus.reg_write  = 1'b0;
      bus.dump_start = 1'b0;
      bus.dbg_ready  = toggle ? ~bus.dbg_ready : 1'b1;
      if (extras && exp_q.size() > 0) begin
        if (cycles == 6) bus.dump_start = 1'b1;
        if (!bus.dbg_ready && !did_stall_wr && exp_q[0][36:32] == 5'd5) begin
          did_stall_wr = 1;
          bus.reg_write = 1'b1; bus.rd_addr = 5'd5; bus.rd_data = 32'hA5A5_0005;
          mdl[5] = 32'hA5A5_0005;
          exp_q[0] = {5'd5, 32'hA5A5_0005};
        end else if (bus.dbg_ready && !did_byp_wr && exp_q[0][36:32] == 5'd9) begin
          did_byp_wr = 1;
          bus.reg_write = 1'b1; bus.rd_addr = 5'd9; bus.rd_data = 32'h5A5A_0009;
          mdl[9] = 32'h5A5A_0009;
          exp_q[0] = {5'd9, 32'h5A5A_0009};
        end
      end
    end
    bus.reg_write = 1'b0;
    bus.dump_start = 1'b0;
    check("dump_done_seen", {63'd0, bus.dump_done}, 64'd1);
  endtask

  // Scoreboard consumer: every accepted debug word is popped and compared.
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && bus.dbg_valid === 1'b1 && bus.dbg_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("dbg_extra_word", 64'd1, 64'd0);
        end else begin
          logic [36:0] e;
          e = exp_q.pop_front();
          check("dbg_addr", {59'd0, bus.dbg_addr}, {59'd0, e[36:32]});
          check("dbg_data", {32'd0, bus.dbg_data}, {32'd0, e[31:0]});
        end
      end
    end
  end

  initial begin
    int cyc;
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    bus.rs1_addr = 5'd3; bus.rs2_addr = 5'd3;
    bus.reg_write = 1'b1; bus.rd_addr = 5'd3; bus.rd_data = 32'hCAFE;
    bus.dump_start = 1'b1; bus.dbg_ready = 1'b0;
    rst = 1'b1;

    // Reset: outputs zero and reset beats write/dump_start
    @(negedge clk);
    check("rst_rs1", {32'd0, bus.rs1_data}, 64'd0);
    check("rst_rs2", {32'd0, bus.rs2_data}, 64'd0);
    check("rst_dbg_data", {32'd0, bus.dbg_data}, 64'd0);
    check("rst_valid", {63'd0, bus.dbg_valid}, 64'd0);
    check("rst_busy", {63'd0, bus.dump_busy}, 64'd0);
    check("rst_done", {63'd0, bus.dump_done}, 64'd0);
    tick();
    tick();
    rst = 1'b0; bus.reg_write = 1'b0; bus.dump_start = 1'b0;
    @(negedge clk);
    check("post_rst_x3", {32'd0, bus.rs1_data}, 64'd0);
    check("post_rst_valid", {63'd0, bus.dbg_valid}, 64'd0);
    check("post_rst_busy", {63'd0, bus.dump_busy}, 64'd0);
    tick();

    // Basic write/read
    wr(5'd5, 32'hDEAD_BEEF);
    bus.rs1_addr = 5'd5; bus.rs2_addr = 5'd0;
    @(negedge clk);
    check("rd_x5", {32'd0, bus.rs1_data}, {32'd0, 32'hDEAD_BEEF});
    check("rd_x0", {32'd0, bus.rs2_data}, 64'd0);
    tick();

    // x0 write discarded
    wr(5'd0, 32'hFFFF_FFFF);
    bus.rs1_addr = 5'd0; bus.rs2_addr = 5'd0;
    @(negedge clk);
    check("x0_rs1", {32'd0, bus.rs1_data}, 64'd0);
    check("x0_rs2", {32'd0, bus.rs2_data}, 64'd0);
    tick();

    // Same-cycle bypass on both ports
    bus.reg_write = 1'b1; bus.rd_addr = 5'd7; bus.rd_data = 32'h1234_5678;
    bus.rs1_addr = 5'd7; bus.rs2_addr = 5'd7;
    mdl[7] = 32'h1234_5678;
    @(negedge clk);
    check("byp_rs1", {32'd0, bus.rs1_data}, {32'd0, 32'h1234_5678});
    check("byp_rs2", {32'd0, bus.rs2_data}, {32'd0, 32'h1234_5678});
    tick();
    bus.reg_write = 1'b0;
    bus.rs2_addr = 5'd5;
    @(negedge clk);
    check("stored_x7", {32'd0, bus.rs1_data}, {32'd0, 32'h1234_5678});
    check("indep_x5", {32'd0, bus.rs2_data}, {32'd0, 32'hDEAD_BEEF});
    tick();

    // Full dump with dbg_ready held high
    for (int i = 1; i < 32; i++) wr(5'(i), 32'(i * 32'h11));
    bus.dbg_ready = 1'b1;
    start_dump();
    run_dump(1'b0, 1'b0, 200, cyc);
    check("dump_cycles", 64'(cyc), 64'd33);
    check("done_valid", {63'd0, bus.dbg_valid}, 64'd0);
    check("done_busy", {63'd0, bus.dump_busy}, 64'd1);
    check("q_empty_1", 64'(exp_q.size()), 64'd0);
    tick();
    @(negedge clk);
    check("done_pulse_end", {63'd0, bus.dump_done}, 64'd0);
    check("idle_busy", {63'd0, bus.dump_busy}, 64'd0);
    tick();

    // Dump with alternating ready, stalled write, bypassed transfer, stray start
    bus.dbg_ready = 1'b1;
    start_dump();
    run_dump(1'b1, 1'b1, 300, cyc);
    check("q_empty_2", 64'(exp_q.size()), 64'd0);
    tick();
    bus.dbg_ready = 1'b1;
    bus.rs1_addr = 5'd5; bus.rs2_addr = 5'd9;
    @(negedge clk);
    check("dump_wr_x5", {32'd0, bus.rs1_data}, {32'd0, 32'hA5A5_0005});
    check("dump_wr_x9", {32'd0, bus.rs2_data}, {32'd0, 32'h5A5A_0009});
    tick();

    // Reset mid-dump at dbg_addr 10
    start_dump();
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1;
    @(negedge clk);
    check("abort_addr", {59'd0, bus.dbg_addr}, 64'd10);
    check("abort_valid", {63'd0, bus.dbg_valid}, 64'd0);
    exp_q.delete();
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_done", {63'd0, bus.dump_done}, 64'd0);
      check("abort_idle", {62'd0, bus.dump_busy, bus.dbg_valid}, 64'd0);
      tick();
    end
    for (int i = 0; i < 16; i++) begin
      bus.rs1_addr = 5'(i); bus.rs2_addr = 5'(i + 16);
      @(negedge clk);
      check("clr_rs1", {32'd0, bus.rs1_data}, 64'd0);
      check("clr_rs2", {32'd0, bus.rs2_data}, 64'd0);
      tick();
    end
    start_dump();
    run_dump(1'b0, 1'b0, 200, cyc);
    check("zero_dump_cycles", 64'(cyc), 64'd33);
    check("q_empty_3", 64'(exp_q.size()), 64'd0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
